// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage (EXE -> MEM -> WB)
//
// Registers the EXE->MEM payload, aligns and extends load data returned by the
// synchronous data SRAM, selects the product half from the shared booth
// multiplier, and drives the MEM->WB bus and the bypass/hazard information
// used by the decode stage.
//
// Handshake: a payload moves from EXE into MEM on a rising edge where
// es2ms_valid & ms_allowin are both 1, and moves from MEM into WB on a rising
// edge where ms2ws_valid & ws_allowin are both 1. The stage always finishes
// in one cycle, so ms_allowin = ~ms_valid | ws_allowin. While MEM holds a
// payload that WB refuses, every register and output is held.
//
// Optional feature (macro MEM_RDATA_BUF_EN):
//   defined     : a 32-bit hold register captures data_sram_rdata on the first
//                 stalled cycle of a load, so the SRAM may be reused by the
//                 next EXE request while the load waits for WB.
//   not defined : data_sram_rdata is used live; it must stay stable while a
//                 load is stalled in MEM.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   es2ms_valid        EXE payload valid
//   ms_allowin         MEM accepts a payload this cycle
//   es2ms_bus          {pc,alu_op[18:0],alu_result,load_op[4:0],dest,gr_we}
//   es_res_from_mul    EXE instruction is mul.w / mulh.w / mulh.wu
//   mul_result         booth product, valid while the mul instr is in MEM
//   data_sram_rdata    SRAM read data for the load currently in MEM
//   ws_allowin         WB accepts a payload
//   ms2ws_valid        MEM payload valid towards WB
//   ms2ws_bus          {pc,final_result,dest,gr_we}
//   mem_dest           destination register (0 when MEM is empty)
//   mem_rf_we          MEM instr writes the register file
//   mem_fwd_data       final_result for bypassing
//   mem_is_load        MEM instr is a load (load-use hazard detection)
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int ES2MS_W = 94,
  parameter int MS2WS_W = 70
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               es2ms_valid,
  output logic               ms_allowin,
  input  logic [ES2MS_W-1:0] es2ms_bus,
  input  logic               es_res_from_mul,
  input  logic [67:0]        mul_result,
  input  logic [31:0]        data_sram_rdata,
  input  logic               ws_allowin,
  output logic               ms2ws_valid,
  output logic [MS2WS_W-1:0] ms2ws_bus,
  output logic [4:0]         mem_dest,
  output logic               mem_rf_we,
  output logic [31:0]        mem_fwd_data,
  output logic               mem_is_load
);

  // -------------------------------------------------------------------------
  // Stage registers
  // -------------------------------------------------------------------------
  logic               ms_valid_q, ms_valid_d;
  logic [ES2MS_W-1:0] es2ms_bus_q, es2ms_bus_d;
  logic               res_from_mul_q, res_from_mul_d;

  always_comb begin
    ms_allowin     = ~ms_valid_q | ws_allowin;
    ms_valid_d     = ms_valid_q;
    es2ms_bus_d    = es2ms_bus_q;
    res_from_mul_d = res_from_mul_q;
    if (ms_allowin) begin
      ms_valid_d = es2ms_valid;
    end
    // A bubble only clears valid; the payload keeps its old value.
    if (es2ms_valid && ms_allowin) begin
      es2ms_bus_d    = es2ms_bus;
      res_from_mul_d = es_res_from_mul;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q     <= 1'b0;
      es2ms_bus_q    <= '0;
      res_from_mul_q <= 1'b0;
    end else begin
      ms_valid_q     <= ms_valid_d;
      es2ms_bus_q    <= es2ms_bus_d;
      res_from_mul_q <= res_from_mul_d;
    end
  end

  // -------------------------------------------------------------------------
  // Payload fields
  // -------------------------------------------------------------------------
  logic [31:0] ms_pc;
  logic [18:0] ms_alu_op;
  logic [31:0] ms_alu_result;
  logic [4:0]  ms_load_op;
  logic [4:0]  ms_dest;
  logic        ms_gr_we;
  logic        ms_is_load;

  assign ms_pc         = es2ms_bus_q[93:62];
  assign ms_alu_op     = es2ms_bus_q[61:43];
  assign ms_alu_result = es2ms_bus_q[42:11];
  assign ms_load_op    = es2ms_bus_q[10:6];
  assign ms_dest       = es2ms_bus_q[5:1];
  assign ms_gr_we      = es2ms_bus_q[0];
  assign ms_is_load    = |ms_load_op;

  // -------------------------------------------------------------------------
  // Load word source
  // -------------------------------------------------------------------------
  logic [31:0] load_word;

`ifdef MEM_RDATA_BUF_EN
  logic [31:0] rbuf_q, rbuf_d;
  logic        rbuf_vld_q, rbuf_vld_d;

  always_comb begin
    rbuf_d     = rbuf_q;
    rbuf_vld_d = rbuf_vld_q;
    if (ms_valid_q && ws_allowin) begin
      // The instruction leaves MEM; whatever enters next reads the SRAM live.
      rbuf_vld_d = 1'b0;
    end else if (ms_valid_q && ms_is_load && !ws_allowin && !rbuf_vld_q) begin
      // First stalled cycle: the SRAM still returns this load's word.
      rbuf_d     = data_sram_rdata;
      rbuf_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rbuf_q     <= '0;
      rbuf_vld_q <= 1'b0;
    end else begin
      rbuf_q     <= rbuf_d;
      rbuf_vld_q <= rbuf_vld_d;
    end
  end

  assign load_word = rbuf_vld_q ? rbuf_q : data_sram_rdata;
`else
  assign load_word = data_sram_rdata;
`endif

  // -------------------------------------------------------------------------
  // Load alignment / extension and result select
  // -------------------------------------------------------------------------
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] mul_data;
  logic [31:0] final_result;

  always_comb begin
    unique case (ms_alu_result[1:0])
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
    // Misaligned halfword/word accesses simply ignore the low address bits.
    load_half = ms_alu_result[1] ? load_word[31:16] : load_word[15:0];

    if (ms_load_op[0]) begin
      load_data = {{24{load_byte[7]}}, load_byte};
    end else if (ms_load_op[3]) begin
      load_data = {24'h0, load_byte};
    end else if (ms_load_op[1]) begin
      load_data = {{16{load_half[15]}}, load_half};
    end else if (ms_load_op[4]) begin
      load_data = {16'h0, load_half};
    end else begin
      load_data = load_word;
    end

    // mul.w takes the low product word; mulh.w / mulh.wu take the high word.
    mul_data = ms_alu_op[12] ? mul_result[31:0] : mul_result[63:32];

    if (ms_is_load) begin
      final_result = load_data;
    end else if (res_from_mul_q) begin
      final_result = mul_data;
    end else begin
      final_result = ms_alu_result;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ms2ws_valid  = ms_valid_q;
  assign ms2ws_bus    = {ms_pc, final_result, ms_dest, ms_gr_we};
  assign mem_dest     = ms_valid_q ? ms_dest : 5'd0;
  assign mem_rf_we    = ms_valid_q & ms_gr_we;
  assign mem_fwd_data = final_result;
  assign mem_is_load  = ms_valid_q & ms_is_load;

  // Operation bits decoded by other stages and the unused product extension.
  logic unused_bits;
  assign unused_bits = ^{ms_alu_op[18:15], ms_alu_op[11:0], mul_result[67:64]};

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// A reference model holds the expected MEM->WB bus of the instruction in MEM
// in exp_q; expected results are computed from the load/mul/alu rules when an
// instruction is accepted.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        resetn;
  always #5 clk = ~clk;

  logic        es2ms_valid;
  logic        ms_allowin;
  logic [93:0] es2ms_bus;
  logic        es_res_from_mul;
  logic [67:0] mul_result;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms2ws_valid;
  logic [69:0] ms2ws_bus;
  logic [4:0]  mem_dest;
  logic        mem_rf_we;
  logic [31:0] mem_fwd_data;
  logic        mem_is_load;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .es2ms_valid     (es2ms_valid),
    .ms_allowin      (ms_allowin),
    .es2ms_bus       (es2ms_bus),
    .es_res_from_mul (es_res_from_mul),
    .mul_result      (mul_result),
    .data_sram_rdata (data_sram_rdata),
    .ws_allowin      (ws_allowin),
    .ms2ws_valid     (ms2ws_valid),
    .ms2ws_bus       (ms2ws_bus),
    .mem_dest        (mem_dest),
    .mem_rf_we       (mem_rf_we),
    .mem_fwd_data    (mem_fwd_data),
    .mem_is_load     (mem_is_load)
  );

  // ---------------------------------------------------------------- scoreboard
  int          n_vec = 0;
  int          n_err = 0;
  logic [69:0] exp_q[$];
  logic [31:0] cur_rdata = '0;
  logic [67:0] cur_mul   = '0;
  logic        cur_load  = 1'b0;

  task automatic check(input string tag, input logic [69:0] act, input logic [69:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [93:0] mk_bus(input logic [31:0] pc, input logic [18:0] op,
                                         input logic [31:0] res, input logic [4:0] lop,
                                         input logic [4:0] dest, input logic we);
    return {pc, op, res, lop, dest, we};
  endfunction

  // Expected MEM->WB bus for a given EXE payload and the SRAM/multiplier data.
  function automatic logic [69:0] ref_bus(input logic [93:0] b, input logic fm,
                                          input logic [31:0] rd, input logic [67:0] mr);
    logic [31:0] pc, res, addr;
    logic [18:0] op;
    logic [4:0]  lop;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    pc     = b[93:62];
    op     = b[61:43];
    addr   = b[42:11];
    lop    = b[10:6];
    byte_v = 8'(rd >> (8 * addr[1:0]));
    half_v = 16'(rd >> (16 * addr[1]));
    if (lop[0])      res = 32'($signed(byte_v));
    else if (lop[1]) res = 32'($signed(half_v));
    else if (lop[2]) res = rd;
    else if (lop[3]) res = 32'(byte_v);
    else if (lop[4]) res = 32'(half_v);
    else if (fm)     res = op[12] ? mr[31:0] : mr[63:32];
    else             res = addr;
    return {pc, res, b[5:1], b[0]};
  endfunction

  // ---------------------------------------------------------------- driver
  // One clock cycle: drive inputs after the falling edge, check outputs,
  // then advance the model as the next rising edge will.
  task automatic step(input logic ev, input logic [93:0] bus, input logic fm,
                      input logic [31:0] rd, input logic [67:0] mr, input logic wa);
    logic exp_v;
    logic allow;
    @(negedge clk);
    exp_v           = (exp_q.size() != 0);
    es2ms_valid     = ev;
    es2ms_bus       = bus;
    es_res_from_mul = fm;
    ws_allowin      = wa;
    data_sram_rdata = exp_v ? cur_rdata : $urandom;
    mul_result      = exp_v ? cur_mul : {4'($urandom), $urandom, $urandom};
    #1;
    allow = !exp_v || wa;
    check("ms2ws_valid", 70'(ms2ws_valid), 70'(exp_v));
    check("ms_allowin", 70'(ms_allowin), 70'(allow));
    if (exp_v) begin
      check("ms2ws_bus", ms2ws_bus, exp_q[0]);
      check("mem_fwd_data", 70'(mem_fwd_data), 70'(exp_q[0][37:6]));
      check("mem_dest", 70'(mem_dest), 70'(exp_q[0][5:1]));
      check("mem_rf_we", 70'(mem_rf_we), 70'(exp_q[0][0]));
      check("mem_is_load", 70'(mem_is_load), 70'(cur_load));
    end else begin
      check("mem_dest_idle", 70'(mem_dest), 70'(0));
      check("mem_rf_we_idle", 70'(mem_rf_we), 70'(0));
      check("mem_is_load_idle", 70'(mem_is_load), 70'(0));
    end
    if (exp_v && wa) void'(exp_q.pop_front());
    if (allow && ev) begin
      exp_q.push_back(ref_bus(bus, fm, rd, mr));
      cur_rdata = rd;
      cur_mul   = mr;
      cur_load  = |bus[10:6];
    end
  endtask

  // Random instruction: a one-hot load, a mul variant, or a plain ALU op.
  task automatic rand_instr(output logic [93:0] bus, output logic fm);
    int          kind;
    logic [18:0] op;
    logic [4:0]  lop;
    kind = $urandom_range(0, 7);
    op   = 19'($urandom);
    op[14:12] = 3'b000;
    lop  = 5'd0;
    fm   = 1'b0;
    if (kind <= 4) begin
      lop[kind] = 1'b1;
    end else if (kind == 5) begin
      fm = 1'b1;
      op[12 + $urandom_range(0, 2)] = 1'b1;
    end
    bus = mk_bus($urandom, op, $urandom, lop, 5'($urandom), 1'($urandom));
  endtask

  logic [93:0] rb;
  logic        rfm;

  // ---------------------------------------------------------------- stimulus
  initial begin
    resetn = 1'b0;
    es2ms_valid = 1'b0; es2ms_bus = '0; es_res_from_mul = 1'b0;
    mul_result = '0; data_sram_rdata = '0; ws_allowin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ms2ws_valid", 70'(ms2ws_valid), 70'(0));
    check("rst_ms_allowin", 70'(ms_allowin), 70'(1));
    check("rst_mem_rf_we", 70'(mem_rf_we), 70'(0));
    check("rst_mem_is_load", 70'(mem_is_load), 70'(0));
    check("rst_mem_dest", 70'(mem_dest), 70'(0));
    check("rst_ms2ws_bus", ms2ws_bus, 70'(0));
    resetn = 1'b1;

    // ld.b, byte 3 sign-extended
    step(1, mk_bus(32'h1c00_0000, 19'd0, 32'h1003, 5'b00001, 5'd3, 1), 0, 32'h80FF_1234, '0, 1);
    step(0, '0, 0, '0, '0, 1);
    check("t1_ld_b", 70'(mem_fwd_data), 70'(32'hFFFF_FF80));

    // ld.hu, upper half zero-extended
    step(1, mk_bus(32'h1c00_0004, 19'd0, 32'h2002, 5'b10000, 5'd4, 1), 0, 32'h8001_7FFF, '0, 1);
    step(0, '0, 0, '0, '0, 1);
    check("t2_ld_hu", 70'(mem_fwd_data), 70'(32'h0000_8001));

    // mulh.wu then mul.w, back to back
    step(1, mk_bus(32'h1c00_0008, 19'h4000, 32'h5555, 5'd0, 5'd5, 1), 1,
         '0, {4'h0, 32'hDEAD_BEEF, 32'h0BAD_F00D}, 1);
    step(1, mk_bus(32'h1c00_000c, 19'h1000, 32'h6666, 5'd0, 5'd6, 1), 1,
         '0, {4'h0, 32'h0BAD_F00D, 32'h1234_5678}, 1);
    check("t3_mulh_wu", 70'(mem_fwd_data), 70'(32'hDEAD_BEEF));
    step(0, '0, 0, '0, '0, 1);
    check("t3_mul_w", 70'(mem_fwd_data), 70'(32'h1234_5678));

    // ld.w stalled three cycles while EXE keeps offering a new payload
    step(1, mk_bus(32'h1c00_0010, 19'd0, 32'h3000, 5'b00100, 5'd7, 1), 0, 32'h1111_1111, '0, 1);
    for (int i = 0; i < 3; i++) begin
      rand_instr(rb, rfm);
      step(1, rb, rfm, $urandom, '0, 0);
      check("t4_stall_data", 70'(mem_fwd_data), 70'(32'h1111_1111));
`ifdef MEM_RDATA_BUF_EN
      cur_rdata = 32'h2222_2222;
`endif
    end
    step(0, '0, 0, '0, '0, 1);
    check("t4_release_data", 70'(mem_fwd_data), 70'(32'h1111_1111));

    // continuous flow, then a bubble
    for (int i = 0; i < 8; i++) begin
      rand_instr(rb, rfm);
      step(1, rb, rfm, $urandom, {4'($urandom), $urandom, $urandom}, 1);
    end
    step(0, '0, 0, '0, '0, 1);
    step(0, '0, 0, '0, '0, 1);
    check("t5_bubble_valid", 70'(ms2ws_valid), 70'(0));
    check("t5_bubble_rf_we", 70'(mem_rf_we), 70'(0));

    // reset asserted while a load is stalled
    step(1, mk_bus(32'h1c00_0020, 19'd0, 32'h4001, 5'b00001, 5'd9, 1), 0, 32'h0000_7F00, '0, 1);
    step(0, '0, 0, '0, '0, 0);
    resetn = 1'b0;
    #1;
    check("t6_rst_valid", 70'(ms2ws_valid), 70'(0));
    check("t6_rst_rf_we", 70'(mem_rf_we), 70'(0));
    check("t6_rst_is_load", 70'(mem_is_load), 70'(0));
    check("t6_rst_allowin", 70'(ms_allowin), 70'(1));
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;

    // randomized traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      rand_instr(rb, rfm);
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, rb, rfm, $urandom,
           {4'($urandom), $urandom, $urandom}, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end

    // ---------------------------------------------------------------- report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
